obf_key_loader: RTL and testbench
=================================

Name: obf_key_loader

Overview:
- Sequential key-delivery stage directly upstream of the camouflaged/obfuscated combinational netlists.
- Receives the obfuscation key serially, checks it with an even-parity bit, and commits it atomically to a stable parallel register.
- That register drives the netlist's key inputs D_0..D_{KEY_W-1}.
- Key outputs never glitch mid-load; an uncommitted or corrupt key never reaches the netlist.

Parameters:
- KEY_W, 4, key width in bits; bit i drives D_i.
- RST_KEY, 0, KEY_W-bit value of key_out after reset and after a failed load.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_start  input  1  single-cycle pulse; begins a load.
- key_sen  input  1  shift enable; key_sdi is sampled on cycles where it is high.
- key_sdi  input  1  serial key bit. Order is LSB first: D_0 first, then the parity bit last.
- key_abort  input  1  cancels an in-progress load.
- key_out  output  KEY_W  committed key; connects to D_0..D_{KEY_W-1}.
- key_valid  output  1  high while key_out holds a parity-checked key.
- key_err  output  1  sticky; set on a parity failure.
- busy  output  1  high in SHIFT or CHECK.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, key_out=RST_KEY, key_valid=0, key_err=0, busy=0.
  - Shift register and bit counter are cleared.
  - Reset in any state, including mid-shift, discards partial data immediately.
- States: IDLE, SHIFT, CHECK, COMMIT.
- IDLE:
  - key_start=1 -> SHIFT. Clear the counter and shift register, clear key_err, busy=1 next cycle.
  - key_out and key_valid are unchanged.
- SHIFT:
  - Each cycle with key_sen=1: shift key_sdi in and increment the counter (width clog2(KEY_W+2)).
  - key_sen=0: hold.
  - After KEY_W+1 accepted bits (KEY_W key bits plus parity) -> CHECK.
  - key_start in SHIFT is ignored.
- CHECK (1 cycle):
  - Compute XOR of all KEY_W+1 bits.
  - Result 0 -> COMMIT.
  - Result 1 -> IDLE with key_err=1, key_valid=0, key_out=RST_KEY. This fails safe: the old key is dropped.
- COMMIT (1 cycle):
  - key_out <= shifted key, key_valid <= 1, then -> IDLE.
  - busy deasserts in the same cycle.
- key_abort=1 in SHIFT or CHECK -> IDLE next edge; key_out, key_valid, key_err unchanged. key_abort has priority over shift and check.
- Simultaneous key_start and key_abort in IDLE: abort wins, stay IDLE.
- Latency: key_start to key_valid rising = 1 + (KEY_W+1 sampled cycles) + 2. With KEY_W=4 and key_sen held high, that is 8 cycles.
- During any reload, key_out keeps its previous committed value until COMMIT or a parity failure. key_valid stays high during reload if it was high.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro OBF_KEY_LOCK_ONCE_EN.
- Defined:
  - After the first successful COMMIT, a lock flag is set; it clears only on rst_n.
  - While locked, key_start is ignored, busy stays 0, and key_out/key_valid are frozen.
  - Adds a 1-bit output key_locked, reset 0, set in the COMMIT cycle.
- Undefined: unlimited reloads, and no key_locked port.

Test Plan:
- Reset then idle 5 cycles -> key_out=4'b0000, key_valid=0, key_err=0, busy=0.
- key_start, then key_sen=1 with sdi 0,1,0,1,0 (key 4'b1010, parity 0) -> key_out=4'b1010, key_valid=1 exactly 8 cycles after key_start, key_err=0.
- Load 4'b1010, then load 4'b0111 with bad parity 0 (bits 1,1,1,0,0) -> key_err=1, key_valid=0, key_out=4'b0000. key_out reads 4'b1010 throughout SHIFT.
- key_start, 2 bits, key_abort -> IDLE next cycle, busy=0, prior key_out unchanged. Then a full load of 4'b0011 (1,1,0,0,0) commits correctly.
- key_sen toggled 1/0 during SHIFT of 4'b1100 (0,0,1,1,0) -> only enabled cycles count; commit yields 4'b1100. rst_n pulsed low mid-SHIFT -> all outputs at reset values asynchronously.
- OBF_KEY_LOCK_ONCE_EN: commit 4'b1010, then a second valid load of 4'b0101 -> ignored, key_out=4'b1010, key_locked=1, busy=0.

Source files
------------

// File: rtl/obf_key_loader.sv
// Loads an obfuscation key serially (LSB first, even parity last) and commits it atomically to key_out.
// Latency: key_start to key_valid = 1 + (KEY_W+1 sampled bits) + 2 cycles; all outputs registered.
// Backpressure: none; key_sen stalls the shift, key_abort cancels a load, and key_start is ignored while busy.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   key_start         single-cycle pulse that begins a load (taken only in IDLE)
//   key_sen, key_sdi  shift enable and serial data (D_0 first, parity bit last)
//   key_abort         cancels a load in progress; also wins over key_start in IDLE
//   key_out           committed key, bit i drives netlist input D_i
//   key_valid         key_out holds a parity-checked key
//   key_err           sticky parity-failure flag, cleared when the next load starts
//   busy              high while in SHIFT or CHECK
//   key_locked        only with OBF_KEY_LOCK_ONCE_EN: set by the first commit, cleared only by reset
//
// Optional feature: define OBF_KEY_LOCK_ONCE_EN to allow a single commit per reset.
module obf_key_loader #(
    parameter int               KEY_W   = 4,
    parameter logic [KEY_W-1:0] RST_KEY = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_sen,
    input  logic             key_sdi,
    input  logic             key_abort,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy
`ifdef OBF_KEY_LOCK_ONCE_EN
    ,
    output logic             key_locked
`endif
);

    localparam int               CNT_W    = $clog2(KEY_W + 2);
    // The counter value seen while the parity bit (the last bit) is shifted in.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [KEY_W:0]     r_shreg;    // [KEY_W] = parity bit, [KEY_W-1:0] = key with D_0 at bit 0
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_key;
    logic               r_valid;
    logic               r_err;
    logic               r_busy;
    logic               w_start_ok;
    logic               w_par_bad;

`ifdef OBF_KEY_LOCK_ONCE_EN
    logic               r_locked;
    assign w_start_ok = key_start & ~key_abort & ~r_locked;
    assign key_locked = r_locked;
`else
    assign w_start_ok = key_start & ~key_abort;
`endif

    // Even parity over key bits and parity bit: any odd count of ones is corrupt.
    assign w_par_bad = ^r_shreg;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (key_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (key_sen && (r_cnt == CNT_LAST)) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (key_abort || w_par_bad) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_key    <= RST_KEY;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
`ifdef OBF_KEY_LOCK_ONCE_EN
            r_locked <= 1'b0;
`endif
        end else begin
            // busy follows the next state so it is registered yet aligned with SHIFT/CHECK.
            r_busy <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_CHECK);
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!key_abort && key_sen) begin
                        // LSB-first stream: new bits enter at the top and migrate down.
                        r_shreg <= {key_sdi, r_shreg[KEY_W:1]};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Fail safe: a corrupt key also drops the previously committed one.
                    if (!key_abort && w_par_bad) begin
                        r_err   <= 1'b1;
                        r_valid <= 1'b0;
                        r_key   <= RST_KEY;
                    end
                end
                ST_COMMIT: begin
                    r_key    <= r_shreg[KEY_W-1:0];
                    r_valid  <= 1'b1;
`ifdef OBF_KEY_LOCK_ONCE_EN
                    r_locked <= 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign key_out   = r_key;
    assign key_valid = r_valid;
    assign key_err   = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_obf_key_loader.sv
module tb_obf_key_loader;

    localparam int KEY_W = 4;

    logic             clk;
    logic             rst_n;
    logic             key_start;
    logic             key_sen;
    logic             key_sdi;
    logic             key_abort;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_err;
    logic             busy;
`ifdef OBF_KEY_LOCK_ONCE_EN
    logic             key_locked;
`endif

    obf_key_loader #(.KEY_W(KEY_W), .RST_KEY(4'b0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_start (key_start),
        .key_sen   (key_sen),
        .key_sdi   (key_sdi),
        .key_abort (key_abort),
        .key_out   (key_out),
        .key_valid (key_valid),
        .key_err   (key_err),
        .busy      (busy)
`ifdef OBF_KEY_LOCK_ONCE_EN
        ,
        .key_locked(key_locked)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: what the committed outputs should be.
    logic [KEY_W-1:0] m_key;
    logic             m_valid;
    logic             m_err;
    logic             m_locked;

    // Scoreboard entries: {key_out, key_valid, key_err}
    logic [KEY_W+1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key    = '0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_locked = 1'b0;
        sb_q.delete();
    endtask

    // Full serial load. bits[0] is D_0, bits[KEY_W] is the parity bit.
    // gap inserts a key_sen=0 cycle (with junk sdi) before every accepted bit.
    task automatic load(input logic [KEY_W:0] bits, input bit gap, output int lat);
        int               n;
        logic [KEY_W-1:0] prev_key;
        logic             prev_valid;
        prev_key   = m_key;
        prev_valid = m_valid;
        if (!m_locked) begin
            m_err = 1'b0;
            if (^bits) begin
                m_key   = '0;
                m_valid = 1'b0;
                m_err   = 1'b1;
            end else begin
                m_key   = bits[KEY_W-1:0];
                m_valid = 1'b1;
`ifdef OBF_KEY_LOCK_ONCE_EN
                m_locked = 1'b1;
`endif
            end
        end
        sb_q.push_back({m_key, m_valid, m_err});

        lat = -1;
        n   = 0;
        key_start = 1'b1;
        @(negedge clk); n++;
        key_start = 1'b0;
        for (int i = 0; i <= KEY_W; i++) begin
            if (gap) begin
                key_sen = 1'b0;
                key_sdi = 1'($urandom_range(0, 1));
                @(negedge clk); n++;
            end
            // Committed key must not move while the new one is still shifting in.
            chk("hold_during_shift", {key_out, key_valid}, {prev_key, prev_valid});
            key_sen = 1'b1;
            key_sdi = bits[i];
            @(negedge clk); n++;
            if (lat < 0 && key_valid && !prev_valid) lat = n;
        end
        key_sen = 1'b0;
        for (int k = 0; k < 20 && busy; k++) begin
            @(negedge clk); n++;
            if (lat < 0 && key_valid && !prev_valid) lat = n;
        end
        chk("busy_done", busy, 0);
        @(negedge clk); n++;
        if (lat < 0 && key_valid && !prev_valid) lat = n;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            chk("result", {key_out, key_valid, key_err}, sb_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        key_start = 1'b0;
        key_sen   = 1'b0;
        key_sdi   = 1'b0;
        key_abort = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int lat;

        // Reset then idle.
        do_reset();
        repeat (5) @(negedge clk);
        chk("rst_key_out", key_out, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_busy", busy, 0);
`ifdef OBF_KEY_LOCK_ONCE_EN
        chk("rst_key_locked", key_locked, 0);
`endif

        // Good load of 1010 with latency check.
        load(5'b01010, 1'b0, lat);
        chk("latency", lat, 8);

        // Bad-parity reload of 0111: fail-safe drop of the old key.
        load(5'b00111, 1'b0, lat);

        // Good load of 0011, then a gapped load of 1100.
        load(5'b00011, 1'b0, lat);
        load(5'b01100, 1'b1, lat);

        // Abort after two bits: outputs unchanged, back to idle next cycle.
        key_start = 1'b1;
        if (!m_locked) m_err = 1'b0;
        @(negedge clk);
        key_start = 1'b0;
        key_sen   = 1'b1;
        key_sdi   = 1'b1;
        @(negedge clk);
        key_sdi   = 1'b0;
        @(negedge clk);
        key_sen   = 1'b0;
        key_abort = 1'b1;
        chk("abort_busy_before", busy, {31'd0, !m_locked});
        @(negedge clk);
        key_abort = 1'b0;
        chk("abort_busy_after", busy, 0);
        chk("abort_keep", {key_out, key_valid, key_err}, {m_key, m_valid, m_err});

        // start and abort together in IDLE: abort wins.
        key_start = 1'b1;
        key_abort = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        key_abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", busy, 0);

        // A full load after the abort still commits from a clean counter.
        load(5'b00011, 1'b0, lat);

        // Reset asserted mid-shift: outputs return to reset values asynchronously.
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        key_sen   = 1'b1;
        key_sdi   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", {key_out, key_valid, key_err, busy}, 0);
        key_sen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("arst_idle_busy", busy, 0);

        // After reset, commit 1010 and try a second valid load of 0101.
        load(5'b01010, 1'b0, lat);
        chk("latency2", lat, 8);
        load(5'b00101, 1'b0, lat);
        chk("final_busy", busy, 0);
`ifdef OBF_KEY_LOCK_ONCE_EN
        chk("lock_key_out", key_out, 4'b1010);
        chk("lock_flag", key_locked, 1);
`else
        chk("reload_key_out", key_out, 4'b0101);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
